// File: rtl/muxn_reg_if.sv
// muxn_reg_if: per-channel valid/ready inputs, selection controls and the registered output handshake.
// The master side drives channel data/valid, sel, mode and out_ready; the slave side is muxn_reg.
interface muxn_reg_if #(
    parameter int D_WIDTH   = 12,
    parameter int N_CH      = 5,
    parameter int SEL_WIDTH = 3
);
    logic [N_CH*D_WIDTH-1:0] in_data;
    logic [N_CH-1:0]         in_valid;
    logic [N_CH-1:0]         in_ready;
    logic [SEL_WIDTH-1:0]    sel;
    logic                    mode;
    logic [D_WIDTH-1:0]      out_data;
    logic [SEL_WIDTH-1:0]    out_ch;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err_sel;
    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_ch, out_valid, err_sel
    );
    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_ch, out_valid, err_sel
    );
endinterface

// File: rtl/muxn_reg.sv
// muxn_reg: N-channel registered selector with direct or round-robin grant and valid/ready on every side.
// Define MUXN_REG_ERR_EN to build the sticky out-of-range sel detector; otherwise err_sel is tied low.
module muxn_reg #(
    parameter int D_WIDTH   = 12,
    parameter int N_CH      = 5,
    parameter int SEL_WIDTH = 3
) (
    input logic      clk,
    input logic      rst,
    muxn_reg_if.slave bus
);
    logic [SEL_WIDTH-1:0] r_ptr;
    logic [SEL_WIDTH-1:0] r_ch;
    logic [D_WIDTH-1:0]   r_data;
    logic                 r_valid;
    logic [SEL_WIDTH-1:0] w_rr;
    logic [SEL_WIDTH-1:0] w_gnt;
    logic [SEL_WIDTH:0]   w_idx;
    logic [D_WIDTH-1:0]   w_gnt_data;
    logic                 w_rr_vld;
    logic                 w_dir_vld;
    logic                 w_gnt_vld;
    logic                 w_load;
    logic                 w_xfer;

    always_comb begin
        w_dir_vld = 1'b0;
        w_rr_vld  = 1'b0;
        w_rr      = '0;
        w_idx     = '0;
        for (int i = 0; i < N_CH; i++)
            if (bus.sel == SEL_WIDTH'(i) && bus.in_valid[i]) w_dir_vld = 1'b1;
        // farthest offset first, so the nearest valid channel after r_ptr overwrites the rest
        for (int k = N_CH; k >= 1; k--) begin
            w_idx = {1'b0, r_ptr} + (SEL_WIDTH+1)'(k);
            w_idx = (w_idx >= (SEL_WIDTH+1)'(N_CH)) ? w_idx - (SEL_WIDTH+1)'(N_CH) : w_idx;
            for (int i = 0; i < N_CH; i++)
                if (bus.in_valid[i] && w_idx == (SEL_WIDTH+1)'(i)) begin
                    w_rr_vld = 1'b1;
                    w_rr     = SEL_WIDTH'(i);
                end
        end
    end

    assign w_gnt_vld = bus.mode ? w_rr_vld : w_dir_vld;
    assign w_gnt     = bus.mode ? w_rr : bus.sel;
    assign w_load    = !r_valid || bus.out_ready;
    assign w_xfer    = !rst && w_load && w_gnt_vld;

    always_comb begin
        bus.in_ready = '0;
        w_gnt_data   = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.in_ready[i] = w_xfer && w_gnt == SEL_WIDTH'(i);
            w_gnt_data      = (w_gnt == SEL_WIDTH'(i)) ? bus.in_data[i*D_WIDTH +: D_WIDTH] : w_gnt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= SEL_WIDTH'(N_CH - 1);
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_gnt_data;
            r_ch    <= w_gnt;
            if (bus.mode) r_ptr <= w_gnt;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.out_data  = r_data;
    assign bus.out_ch    = r_ch;
    assign bus.out_valid = r_valid;

`ifdef MUXN_REG_ERR_EN
    logic r_err;
    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else if (!bus.mode && int'(bus.sel) >= N_CH) r_err <= 1'b1;
    end
    assign bus.err_sel = r_err;
`else
    assign bus.err_sel = 1'b0;
`endif
endmodule

// File: tb/tb_muxn_reg.sv
// tb_muxn_reg: random and directed stimulus on a 5x12 and a 3x32 instance; a grant-rule model
// pushes expected words into per-instance scoreboards that negedge monitors pop and compare.
module tb_muxn_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muxn_reg_if #(.D_WIDTH(12), .N_CH(5), .SEL_WIDTH(3)) b0();
    muxn_reg_if #(.D_WIDTH(32), .N_CH(3), .SEL_WIDTH(2)) b1();
    muxn_reg #(.D_WIDTH(12), .N_CH(5), .SEL_WIDTH(3)) u0 (.clk(clk), .rst(rst), .bus(b0));
    muxn_reg #(.D_WIDTH(32), .N_CH(3), .SEL_WIDTH(2)) u1 (.clk(clk), .rst(rst), .bus(b1));

`ifdef MUXN_REG_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [11:0] d0[5];
    logic [31:0] d1[3];
    bit full0, full1, err0, err1;
    int ptr0, ptr1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Grant from the selection rules: direct index, or first valid channel after ptr, wrapping mod n.
    function automatic int pick(logic [31:0] v, int sel, bit mode, int ptr, int n);
        if (!mode) return (sel < n && v[sel]) ? sel : -1;
        for (int k = 1; k <= n; k++)
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        return -1;
    endfunction

    // Entered at posedge+1: drive one cycle, check in_ready/out_valid/err_sel, advance to next posedge+1.
    task automatic step(logic [4:0] v0, int sel0, bit m0, bit r0, bit quiet1 = 1'b0);
        int g;
        bit ld;
        logic [2:0] v1;
        bit m1, r1;
        int s1;
        v1 = quiet1 ? 3'b000 : 3'($urandom);
        m1 = $urandom_range(0, 3) != 0;
        s1 = $urandom_range(0, 3);
        r1 = quiet1 ? 1'b1 : ($urandom_range(0, 2) != 0);
        for (int i = 0; i < 5; i++) d0[i] = 12'($urandom);
        for (int i = 0; i < 3; i++) d1[i] = $urandom;
        for (int i = 0; i < 5; i++) b0.in_data[i*12 +: 12] = d0[i];
        for (int i = 0; i < 3; i++) b1.in_data[i*32 +: 32] = d1[i];
        b0.in_valid = v0; b0.sel = 3'(sel0); b0.mode = m0; b0.out_ready = r0;
        b1.in_valid = v1; b1.sel = 2'(s1); b1.mode = m1; b1.out_ready = r1;
        #1;
        chk("valid0", 64'(b0.out_valid), 64'(full0));
        chk("err0", 64'(b0.err_sel), 64'(ERR_EN && err0));
        g = pick(32'(v0), sel0, m0, ptr0, 5);
        ld = !full0 || r0;
        chk("ready0", 64'(b0.in_ready), (ld && g >= 0) ? (64'(1) << g) : 64'(0));
        if (ld && g >= 0) begin
            q0.push_back((64'(g) << 12) | 64'(d0[g]));
            full0 = 1'b1;
            if (m0) ptr0 = g;
        end else if (r0) full0 = 1'b0;
        err0 |= !m0 && sel0 >= 5;
        chk("valid1", 64'(b1.out_valid), 64'(full1));
        chk("err1", 64'(b1.err_sel), 64'(ERR_EN && err1));
        g = pick(32'(v1), s1, m1, ptr1, 3);
        ld = !full1 || r1;
        chk("ready1", 64'(b1.in_ready), (ld && g >= 0) ? (64'(1) << g) : 64'(0));
        if (ld && g >= 0) begin
            q1.push_back((64'(g) << 32) | 64'(d1[g]));
            full1 = 1'b1;
            if (m1) ptr1 = g;
        end else if (r1) full1 = 1'b0;
        err1 |= !m1 && s1 >= 3;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(bit r);
        rst = 1'b1;
        b0.in_valid = '1; b0.mode = 1'b1; b0.out_ready = r;
        b1.in_valid = '1; b1.mode = 1'b1; b1.out_ready = r;
        #1;
        chk("rst_ready0", 64'(b0.in_ready), 64'(0));
        chk("rst_ready1", 64'(b1.in_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete(); q1.delete();
        full0 = 1'b0; full1 = 1'b0; err0 = 1'b0; err1 = 1'b0;
        ptr0 = 4; ptr1 = 2;
        chk("rst_valid0", 64'(b0.out_valid), 64'(0));
        chk("rst_data0", 64'(b0.out_data), 64'(0));
        chk("rst_ch0", 64'(b0.out_ch), 64'(0));
        chk("rst_err0", 64'(b0.err_sel), 64'(0));
        chk("rst_valid1", 64'(b1.out_valid), 64'(0));
        chk("rst_data1", 64'(b1.out_data), 64'(0));
        chk("rst_ch1", 64'(b1.out_ch), 64'(0));
    endtask

    always @(negedge clk) begin
        if (!rst && b0.out_valid === 1'b1) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL extra0: got word %0h want no word", {b0.out_ch, b0.out_data});
            end else begin
                chk("out0", 64'({b0.out_ch, b0.out_data}), q0[0]);
                if (b0.out_ready) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b1.out_valid === 1'b1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL extra1: got word %0h want no word", {b1.out_ch, b1.out_data});
            end else begin
                chk("out1", 64'({b1.out_ch, b1.out_data}), q1[0]);
                if (b1.out_ready) void'(q1.pop_front());
            end
        end
    end

    initial begin
        b0.in_data = '0; b0.in_valid = '0; b0.sel = '0; b0.mode = 1'b0; b0.out_ready = 1'b0;
        b1.in_data = '0; b1.in_valid = '0; b1.sel = '0; b1.mode = 1'b0; b1.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b1);
        step(5'b01000, 3, 1'b0, 1'b1);
        step(5'b00000, 0, 1'b0, 1'b1);
        step(5'b11111, 3, 1'b0, 1'b1);
        repeat (3) step(5'b11111, 2, 1'b0, 1'b0);
        step(5'b11111, 2, 1'b0, 1'b1);
        step(5'b00000, 0, 1'b0, 1'b1);
        do_reset(1'b1);
        repeat (6) step(5'b11111, 0, 1'b1, 1'b1);
        repeat (4) step(5'b10010, 0, 1'b1, 1'b1);
        step(5'b11111, 5, 1'b0, 1'b1);
        step(5'b11111, 7, 1'b0, 1'b1);
        step(5'b11111, 7, 1'b0, 1'b1);
        step(5'b11111, 1, 1'b0, 1'b0);
        step(5'b11111, 1, 1'b0, 1'b0);
        do_reset(1'b0);
        step(5'b11111, 0, 1'b1, 1'b1);
        repeat (400) step(5'($urandom), $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        repeat (4) step(5'b00000, 0, 1'b1, 1'b1, 1'b1);
        chk("lost0", 64'(q0.size()), 64'(0));
        chk("lost1", 64'(q1.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
